mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte TX FIFO.
//
// Register map (byte offsets on addr):
//   0x0 TXDATA  W: push wdata[7:0] into the TX FIFO (dropped when full)
//   0x4 STATUS  R: {28'b0, overflow, busy, empty, full}
//               W: wdata[3]=1 clears the sticky overflow bit
//   0x8 BAUDDIV RW: cycles per serial bit, low 16 bits; 0 behaves as 1
//   others      read 0, stores ignored
//
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   sel    access targets this peripheral
//   we     1 = store, 0 = load
//   addr   byte offset
//   wdata  store data
//   rdata  load data, combinational from addr
//   tx     serial line, idle high, registered
//   irq    TX-empty interrupt
//
// Build option: define UART_TX_IRQ_EN to build the registered TX-empty
// interrupt; otherwise irq is tied low.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      div_q, div_d;

  state_e           state_q;
  logic [15:0]      frame_div_q;
  logic [15:0]      baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;

  logic             fifo_empty_c;
  logic             fifo_full_c;
  logic             busy_c;
  logic             bit_done_c;
  logic             push_req_c;
  logic             push_c;
  logic             pop_c;
  logic [15:0]      div_eff_c;

  // Upper store bits have no destination.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  // Bus decode, FIFO bookkeeping and register next-state.
  always_comb begin
    fifo_empty_c = (count_q == '0);
    fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
    busy_c       = (state_q != IDLE);
    bit_done_c   = (baud_cnt_q == '0);
    div_eff_c    = (div_q == '0) ? 16'd1 : div_q;

    // Full is judged on the pre-pop occupancy, so a same-cycle pop never
    // makes room for the push.
    push_req_c = sel && we && (addr == ADDR_TXDATA);
    push_c     = push_req_c && !fifo_full_c;
    pop_c      = !fifo_empty_c &&
                 ((state_q == IDLE) || ((state_q == STOP) && bit_done_c));

    wptr_d = push_c ? (wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d = pop_c  ? (rptr_q + PTR_W'(1)) : rptr_q;

    count_d = count_q;
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (push_req_c && fifo_full_c) begin
      overflow_d = 1'b1;
    end else if (sel && we && (addr == ADDR_STATUS) && wdata[3]) begin
      overflow_d = 1'b0;
    end

    div_d = div_q;
    if (sel && we && (addr == ADDR_BAUDDIV)) begin
      div_d = wdata[15:0];
    end
  end

  // Load data mux.
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_STATUS:  rdata = {28'b0, overflow_q, busy_c, fifo_empty_c, fifo_full_c};
      ADDR_BAUDDIV: rdata = {16'b0, div_q};
      default:      rdata = '0;
    endcase
  end

  // FIFO storage; contents are don't-care while the entry is unoccupied.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_q[wptr_q] <= wdata[7:0];
    end
  end

  // Register file and FIFO pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      div_q      <= DIV_RESET;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      div_q      <= div_d;
    end
  end

  // Serializer FSM. A pop always starts a new frame, whether from IDLE or
  // straight out of the last STOP cycle, and latches the divisor so that
  // BAUDDIV writes never disturb a frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      frame_div_q <= 16'd1;
      baud_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
    end else if (pop_c) begin
      state_q     <= START;
      frame_div_q <= div_eff_c;
      baud_cnt_q  <= div_eff_c - 16'd1;
      bit_idx_q   <= '0;
      shift_q     <= fifo_q[rptr_q];
      tx_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
        end
        START: begin
          if (bit_done_c) begin
            state_q    <= DATA;
            tx_q       <= shift_q[0];
            baud_cnt_q <= frame_div_q - 16'd1;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        DATA: begin
          if (bit_done_c) begin
            baud_cnt_q <= frame_div_q - 16'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        STOP: begin
          // Only reached here when the FIFO is empty at the end of STOP.
          if (bit_done_c) begin
            state_q <= IDLE;
          end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx = tx_q;

`ifdef UART_TX_IRQ_EN
  logic irq_q;
  logic idle_next_c;

  // Look at next-cycle state and occupancy so the push that fills an empty
  // FIFO clears irq on its own edge.
  assign idle_next_c = !pop_c &&
                       ((state_q == IDLE) || ((state_q == STOP) && bit_done_c));

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= idle_next_c && (count_d == '0);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench for mmio_uart_tx.
// The driver issues bus accesses and queues the frames each accepted TXDATA
// store should produce; an independent monitor decodes every frame seen on
// tx, pops the queue and compares byte, bit timing, start latency and gap.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int unsigned DEPTH   = 8;
  localparam logic [15:0] DIV_RST = 16'd868;
`ifdef UART_TX_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_BAUD = 4'h8;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;
  logic        irq;

  mmio_uart_tx #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIV_RST)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
    int         start;  // expected first start-bit cycle, -1 = unchecked
    bit         b2b;    // must follow the previous stop bit with no gap
  } frame_t;

  frame_t exp_q[$];
  int     n_pushed    = 0;
  int     frames_done = 0;
  int     n_chk       = 0;
  int     n_pass      = 0;
  bit     mon_en      = 1'b1;
  int     last_k      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    last_k = cyc;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string name);
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = a;
    #1;
    check(name, rdata, e);
  endtask

  // mode 0: frame from idle (latency k+2), 1: back-to-back, 2: dropped
  task automatic send(input logic [7:0] d, input int dv, input int mode);
    frame_t f;
    bus_write(A_TX, {24'b0, d});
    if (mode != 2) begin
      f.data  = d;
      f.div   = dv;
      f.start = (mode == 0) ? last_k + 2 : -1;
      f.b2b   = (mode == 1);
      exp_q.push_back(f);
      n_pushed++;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (frames_done < n_pushed && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(frames_done), 32'(n_pushed));
  endtask

  // Monitor: decode frames on tx independently of the driver.
  frame_t     mf;
  int         m_err;
  int         m_start;
  int         m_last_end = -100;
  int         m_bp;
  logic       m_exp;
  logic [7:0] m_byte;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset === 1'b0 && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'(tx === 1'b0), 32'd0);
        end else begin
          mf      = exp_q.pop_front();
          m_start = cyc;
          m_err   = 0;
          m_byte  = '0;
          for (int i = 0; i < 10 * mf.div; i++) begin
            if (i != 0) @(negedge clk);
            m_bp  = i / mf.div;
            m_exp = (m_bp == 0) ? 1'b0 : (m_bp == 9) ? 1'b1 : mf.data[m_bp-1];
            if (tx !== m_exp) m_err++;
            if (m_bp >= 1 && m_bp <= 8 && (i % mf.div) == mf.div / 2) m_byte[m_bp-1] = tx;
          end
          check("frame_data", 32'(m_byte), 32'(mf.data));
          check("frame_shape_errs", 32'(m_err), 32'd0);
          if (mf.start >= 0) check("frame_latency", 32'(m_start), 32'(mf.start));
          if (mf.b2b) check("frame_gap", 32'(m_start), 32'(m_last_end + 1));
          m_last_end = cyc;
          frames_done++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; we = 1'b0; addr = '0; wdata = '0; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    rd_chk(A_STAT, 32'h2, "rst_status");
    rd_chk(A_BAUD, 32'(DIV_RST), "rst_bauddiv");
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("irq_after_rst_release", 32'(irq), 32'(IRQ_EN));

    // Single frame 0x55 at div 4
    bus_write(A_BAUD, 32'd4);
    rd_chk(A_BAUD, 32'd4, "baud_rb4");
    send(8'h55, 4, 0);
    bus_idle();
    #1;
    check("irq_after_push", 32'(irq), 32'd0);
    wait_drain(200);
    rd_chk(A_STAT, 32'h2, "status_idle_after_frame");
    check("irq_after_stop", 32'(irq), 32'(IRQ_EN));

    // Overflow: one frame in flight, then 9 stores into an 8-deep FIFO
    send(8'h0F, 4, 0);
    bus_idle();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) send(8'(i * 37 + 3), 4, 1);
    send(8'hEE, 4, 2);
    rd_chk(A_STAT, 32'hD, "status_full_ovf");
    bus_write(A_STAT, 32'h1);
    rd_chk(A_STAT, 32'hD, "status_w1_noeffect");
    bus_write(A_STAT, 32'h8);
    rd_chk(A_STAT, 32'h5, "status_ovf_clr");
    bus_write(4'hC, 32'hFFFF_FFFF);
    rd_chk(4'hC, 32'h0, "unmapped_rd");
    rd_chk(A_TX, 32'h0, "txdata_rd");
    rd_chk(A_BAUD, 32'd4, "baud_after_unmapped_wr");
    bus_idle();
    wait_drain(1000);
    rd_chk(A_STAT, 32'h2, "status_after_burst");

    // Divider change mid-frame applies only to the next frame
    bus_write(A_BAUD, 32'd8);
    send(8'h3C, 8, 0);
    bus_idle();
    repeat (20) @(negedge clk);
    bus_write(A_BAUD, 32'd2);
    rd_chk(A_BAUD, 32'd2, "baud_rb2");
    send(8'hA5, 2, 1);
    bus_idle();
    wait_drain(400);

    // Divider 0 behaves as 1
    bus_write(A_BAUD, 32'd0);
    rd_chk(A_BAUD, 32'd0, "baud_rb0");
    send(8'h81, 1, 0);
    bus_idle();
    wait_drain(100);

    // Reset during DATA bit 3 aborts the frame and discards the queue
    mon_en = 1'b0;
    bus_write(A_BAUD, 32'd4);
    bus_write(A_TX, 32'h55);
    bus_write(A_TX, 32'h33);
    bus_idle();
    while (cyc < last_k - 1 + 19) @(negedge clk);
    check("tx_in_bit3", 32'(tx), 32'd0);
    rd_chk(A_STAT, 32'h4, "status_busy_mid_frame");
    reset = 1'b1;
    @(negedge clk);
    check("tx_after_mid_rst", 32'(tx), 32'd1);
    check("irq_in_rst", 32'(irq), 32'd0);
    reset = 1'b0;
    rd_chk(A_STAT, 32'h2, "status_after_mid_rst");
    rd_chk(A_BAUD, 32'(DIV_RST), "baud_after_mid_rst");
    bus_idle();
    mon_en = 1'b1;
    repeat (60) @(negedge clk);
    check("tx_idle_after_discard", 32'(tx), 32'd1);
    rd_chk(A_STAT, 32'h2, "status_final");
    check("frames_all_seen", 32'(frames_done), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
